// File: rtl/ikaopll_pkg.sv
// Shared definitions for the TDM ring family: tap field width, counter width helper
// and the packed tap-position field type.
package ikaopll_pkg;

    localparam int TAP_FW = 8;

    typedef logic [TAP_FW-1:0] tap_field_t;

    // Width of a counter able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ikaopll_slot_cnt.sv
// Slot counter for TDM pipelines: counts 0..LENGTH-1, restarts on i_SYNC,
// with a registered wrap flag that is high while the count sits on the last slot.
module ikaopll_slot_cnt
    import ikaopll_pkg::*;
#(
    parameter int LENGTH = 18,
    localparam int SW = clog2_min1(LENGTH)
) (
    input  logic          i_EMUCLK,
    input  logic          i_RST_n,
    input  logic          i_CEN_n,
    input  logic          i_SYNC,
    output logic [SW-1:0] o_SLOT,
    output logic          o_WRAP
);

    localparam logic [SW-1:0] LAST_SLOT = SW'(LENGTH - 1);

    logic [SW-1:0] r_cnt;
    logic          r_wrap;
    logic [SW-1:0] w_cnt_next;

    // Resync takes priority; on the wrap tick both paths land on 0 anyway.
    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (i_SYNC) begin
            w_cnt_next = '0;
        end else if (r_cnt == LAST_SLOT) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (!i_CEN_n) begin
            r_cnt  <= w_cnt_next;
            r_wrap <= (w_cnt_next == LAST_SLOT);
        end
    end

    assign o_SLOT = r_cnt;
    assign o_WRAP = r_wrap;

endmodule

// File: rtl/ikaopll_tdm_ring.sv
// Multi-tap TDM shift ring with recirculation, write override and slot tracking.
// Optional debug readback port enabled by defining IKAOPLL_TDM_RING_DBG_EN.
module ikaopll_tdm_ring
    import ikaopll_pkg::*;
#(
    parameter int                     WIDTH  = 8,
    parameter int                     LENGTH = 18,
    parameter int                     NTAP   = 3,
    parameter logic [NTAP*TAP_FW-1:0] TAPS   = {8'd9, 8'd6, 8'd0},
    localparam int                    SW     = clog2_min1(LENGTH)
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_RST_n,
    input  logic                  i_CEN_n,
    input  logic                  i_SYNC,
    input  logic                  i_RECIRC,
    input  logic                  i_WR,
    input  logic [WIDTH-1:0]      i_D,
`ifdef IKAOPLL_TDM_RING_DBG_EN
    input  logic [SW-1:0]         i_DBG_SEL,
    output logic [WIDTH-1:0]      o_DBG_Q,
`endif
    output logic [SW-1:0]         o_SLOT,
    output logic                  o_WRAP,
    output logic [NTAP*WIDTH-1:0] o_Q_TAP,
    output logic [WIDTH-1:0]      o_Q_LAST
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("ikaopll_tdm_ring: WIDTH must be >= 1");
        end
        if (LENGTH < 2) begin : g_bad_length
            $error("ikaopll_tdm_ring: LENGTH must be >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_stage [0:LENGTH-1];
    logic [WIDTH-1:0] w_nxt;

    // A write always lands, even while the ring is recirculating.
    assign w_nxt = (i_WR | ~i_RECIRC) ? i_D : r_stage[LENGTH-1];

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            for (int n = 0; n < LENGTH; n++) begin
                r_stage[n] <= '0;
            end
        end else if (!i_CEN_n) begin
            r_stage[0] <= w_nxt;
            for (int n = 1; n < LENGTH; n++) begin
                r_stage[n] <= r_stage[n-1];
            end
        end
    end

    assign o_Q_LAST = r_stage[LENGTH-1];

    // Tap position 0 is the stage-0 input itself; position m is the output of stage m-1.
    genvar gi;
    generate
        for (gi = 0; gi < NTAP; gi++) begin : g_tap
            localparam tap_field_t TP = TAPS[gi*TAP_FW +: TAP_FW];
            if (int'(TP) > LENGTH) begin : g_out_of_range
                $error("ikaopll_tdm_ring: tap %0d position %0d exceeds LENGTH %0d",
                       gi, TP, LENGTH);
                assign o_Q_TAP[gi*WIDTH +: WIDTH] = '0;
            end else if (int'(TP) == 0) begin : g_input
                assign o_Q_TAP[gi*WIDTH +: WIDTH] = w_nxt;
            end else begin : g_stage
                assign o_Q_TAP[gi*WIDTH +: WIDTH] = r_stage[int'(TP) - 1];
            end
        end
    endgenerate

`ifdef IKAOPLL_TDM_RING_DBG_EN
    assign o_DBG_Q = (int'(i_DBG_SEL) < LENGTH) ? r_stage[i_DBG_SEL] : '0;
`endif

    ikaopll_slot_cnt #(
        .LENGTH (LENGTH)
    ) u_slot_cnt (
        .i_EMUCLK (i_EMUCLK),
        .i_RST_n  (i_RST_n),
        .i_CEN_n  (i_CEN_n),
        .i_SYNC   (i_SYNC),
        .o_SLOT   (o_SLOT),
        .o_WRAP   (o_WRAP)
    );

endmodule

// File: tb/tb_ikaopll_tdm_ring.sv
// Self-checking bench for ikaopll_tdm_ring (default parameters, debug port not built).
module tb_ikaopll_tdm_ring;

    localparam int L = 18;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         cen_n;
    logic         sync;
    logic         recirc;
    logic         wr;
    logic [W-1:0] d;
    logic [4:0]   slot;
    logic         wrap;
    logic [3*W-1:0] q_tap;
    logic [W-1:0] q_last;

    int n_cmp;
    int n_bad;

    int TAP_POS [3] = '{0, 6, 9};

    // Reference model: the ring as a queue of words, newest at index 0.
    logic [W-1:0] m_ring [$];
    int           m_slot;
    bit           m_wrap;

    ikaopll_tdm_ring dut (
        .i_EMUCLK (clk),
        .i_RST_n  (rst_n),
        .i_CEN_n  (cen_n),
        .i_SYNC   (sync),
        .i_RECIRC (recirc),
        .i_WR     (wr),
        .i_D      (d),
        .o_SLOT   (slot),
        .o_WRAP   (wrap),
        .o_Q_TAP  (q_tap),
        .o_Q_LAST (q_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_tap(input int k);
        int p;
        p = TAP_POS[k];
        if (p == 0) return (wr || !recirc) ? d : m_ring[L-1];
        return m_ring[p-1];
    endfunction

    task automatic m_clear();
        m_ring.delete();
        for (int i = 0; i < L; i++) m_ring.push_back('0);
        m_slot = 0;
        m_wrap = 0;
    endtask

    // One clock edge; the model advances with the inputs present at that edge.
    task automatic step();
        logic [W-1:0] nv;
        bit adv;
        adv = rst_n && !cen_n;
        nv  = (wr || !recirc) ? d : m_ring[L-1];
        @(posedge clk);
        if (adv) begin
            m_ring.push_front(nv);
            void'(m_ring.pop_back());
            m_slot = sync ? 0 : ((m_slot == L-1) ? 0 : m_slot + 1);
            m_wrap = (m_slot == L-1);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; cen_n = 0; sync = 0; recirc = 0; wr = 0; d = 8'h3C;
        m_clear();
        repeat (3) step();
        #1;
        n_cmp++;
        if (q_last !== 8'h00) begin n_bad++; $display("FAIL reset_q_last got %h want 00", q_last); end
        n_cmp++;
        if (slot !== 5'd0) begin n_bad++; $display("FAIL reset_slot got %0d want 0", slot); end
        n_cmp++;
        if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
        n_cmp++;
        if (q_tap !== {8'h00, 8'h00, 8'h3C}) begin
            n_bad++; $display("FAIL reset_taps got %h want 00003c", q_tap);
        end
        rst_n = 1;
        $display("test_reset: done");
    endtask

    task automatic test_shift_latency();
        recirc = 0; wr = 0; sync = 0; cen_n = 0; d = 8'hA5;
        #1;
        n_cmp++;
        if (q_tap[7:0] !== 8'hA5) begin n_bad++; $display("FAIL shift_tap0 got %h want a5", q_tap[7:0]); end
        step();
        d = 8'h00;
        for (int t = 1; t <= L; t++) begin
            #1;
            n_cmp++;
            if (q_last !== ((t == L) ? 8'hA5 : 8'h00)) begin
                n_bad++; $display("FAIL shift_q_last t=%0d got %h", t, q_last);
            end
            n_cmp++;
            if (q_tap[15:8] !== ((t == 6) ? 8'hA5 : 8'h00)) begin
                n_bad++; $display("FAIL shift_tap6 t=%0d got %h", t, q_tap[15:8]);
            end
            n_cmp++;
            if (q_tap[23:16] !== ((t == 9) ? 8'hA5 : 8'h00)) begin
                n_bad++; $display("FAIL shift_tap9 t=%0d got %h", t, q_tap[23:16]);
            end
            if (t < L) step();
        end
        $display("test_shift_latency: done");
    endtask

    task automatic test_recirc();
        sync = 1; step(); sync = 0;
        recirc = 0;
        for (int i = 0; i < L; i++) begin
            d = W'(i);
            step();
        end
        recirc = 1; d = 8'hFF;
        for (int i = 0; i < 2*L; i++) begin
            #1;
            n_cmp++;
            if (q_last !== W'(i % L) || slot !== 5'(i % L)) begin
                n_bad++; $display("FAIL recirc i=%0d q_last %h slot %0d want %0d", i, q_last, slot, i % L);
            end
            step();
        end
        $display("test_recirc: done");
    endtask

    task automatic test_write_override();
        recirc = 1;
        for (int i = 0; i < L; i++) begin
            wr = (m_slot == 3);
            d  = wr ? 8'h5C : W'($urandom_range(0, 255));
            step();
        end
        wr = 0;
        for (int i = 0; i < L; i++) begin
            #1;
            n_cmp++;
            if (q_last !== ((i == 3) ? 8'h5C : W'(i))) begin
                n_bad++; $display("FAIL override slot=%0d got %h", i, q_last);
            end
            step();
        end
        $display("test_write_override: done");
    endtask

    task automatic test_cen_stall();
        repeat (4) step();
        cen_n = 1;
        for (int i = 0; i < 5; i++) begin
            sync = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            step();
            n_cmp++;
            if (slot !== 5'(m_slot) || q_last !== m_ring[L-1] || wrap !== m_wrap ||
                q_tap[23:8] !== {m_ring[8], m_ring[5]}) begin
                n_bad++; $display("FAIL cen_stall i=%0d slot %0d want %0d q_last %h want %h",
                                  i, slot, m_slot, q_last, m_ring[L-1]);
            end
        end
        cen_n = 0; sync = 0; wr = 0;
        $display("test_cen_stall: done");
    endtask

    task automatic test_sync();
        int budget;
        budget = 0;
        while (m_slot != 7 && budget < 40) begin step(); budget++; end
        n_cmp++;
        if (slot !== 5'd7) begin n_bad++; $display("FAIL sync_reach slot got %0d want 7", slot); end
        sync = 1; step(); sync = 0;
        n_cmp++;
        if (slot !== 5'd0) begin n_bad++; $display("FAIL sync_restart slot got %0d want 0", slot); end
        for (int i = 0; i < 2*L + 2; i++) begin
            step();
            n_cmp++;
            if (slot !== 5'((i + 1) % L) || wrap !== (slot == 5'(L-1))) begin
                n_bad++; $display("FAIL sync_wrap i=%0d slot %0d wrap %b", i, slot, wrap);
            end
        end
        $display("test_sync: done");
    endtask

    task automatic test_sync_on_wrap();
        int budget;
        budget = 0;
        while (m_slot != L-1 && budget < 40) begin step(); budget++; end
        n_cmp++;
        if (slot !== 5'(L-1) || wrap !== 1'b1) begin
            n_bad++; $display("FAIL syncwrap_reach slot %0d wrap %b want 17/1", slot, wrap);
        end
        sync = 1; step(); sync = 0;
        n_cmp++;
        if (slot !== 5'd0 || wrap !== 1'b0) begin
            n_bad++; $display("FAIL syncwrap_zero slot %0d wrap %b want 0/0", slot, wrap);
        end
        step();
        n_cmp++;
        if (slot !== 5'd1) begin n_bad++; $display("FAIL syncwrap_next slot %0d want 1", slot); end
        $display("test_sync_on_wrap: done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cen_n  = ($urandom_range(0, 3) == 0);
            sync   = ($urandom_range(0, 15) == 0);
            recirc = 1'($urandom_range(0, 1));
            wr     = ($urandom_range(0, 7) == 0);
            d      = W'($urandom_range(0, 255));
            #1;
            n_cmp++;
            if (slot !== 5'(m_slot) || wrap !== m_wrap || q_last !== m_ring[L-1] ||
                q_tap !== {m_tap(2), m_tap(1), m_tap(0)}) begin
                n_bad++;
                $display("FAIL random i=%0d slot %0d/%0d wrap %b/%b last %h/%h taps %h/%h",
                         i, slot, m_slot, wrap, m_wrap, q_last, m_ring[L-1],
                         q_tap, {m_tap(2), m_tap(1), m_tap(0)});
            end
            $display("txn %0d: cen_n=%b sync=%b recirc=%b wr=%b d=%h slot=%0d last=%h",
                     i, cen_n, sync, recirc, wr, d, slot, q_last);
            step();
        end
        cen_n = 0; sync = 0; wr = 0;
        $display("test_random: done");
    endtask

    task automatic test_async_reset();
        recirc = 0; d = 8'h77;
        repeat (10) step();
        #2;
        rst_n = 0;
        #1;
        m_clear();
        n_cmp++;
        if (q_last !== 8'h00 || q_tap[23:8] !== 16'h0000) begin
            n_bad++; $display("FAIL async_reset_data last %h taps %h want 0", q_last, q_tap);
        end
        n_cmp++;
        if (slot !== 5'd0 || wrap !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_slot slot %0d wrap %b want 0/0", slot, wrap);
        end
        step();
        rst_n = 1; d = 8'h11;
        step();
        n_cmp++;
        if (slot !== 5'd1 || q_tap[15:8] !== 8'h00 || m_ring[0] !== 8'h11) begin
            n_bad++; $display("FAIL async_reset_resume slot %0d want 1 tap6 %h", slot, q_tap[15:8]);
        end
        $display("test_async_reset: done");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_shift_latency();
        test_recirc();
        test_write_override();
        test_cen_stall();
        test_sync();
        test_sync_on_wrap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
